// File: rtl/button_conditioner.sv
// button_conditioner: push-button front end.
// Raw pins pass a 2-flop synchroniser, are debounced against a shared
// millisecond-style tick, and produce a debounced level plus single-cycle
// press, release and long-press pulses per channel.
module button_conditioner #(
    parameter int NUM_BTN        = 4,
    parameter int CLK_FREQ       = 50_000_000,
    parameter int TICK_DIV       = CLK_FREQ / 1000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long,
    output logic               tick
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);

    localparam logic [TW-1:0]      TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0]      DB_LAST   = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0]      HOLD_MAX  = HW'(LONG_TICKS);
    localparam logic [HW-1:0]      HOLD_LAST = HW'(LONG_TICKS - 1);
    // Pin value of a released button; also the synchroniser reset value.
    localparam logic [NUM_BTN-1:0] IDLE_PINS = {NUM_BTN{BTN_ACTIVE_LOW}};

    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic               tick_q, tick_d;
    logic [NUM_BTN-1:0] s1_q, s1_d;
    logic [NUM_BTN-1:0] s2_q, s2_d;
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] release_q, release_d;
    logic [NUM_BTN-1:0] long_q, long_d;
    logic [DW-1:0]      db_cnt_q   [NUM_BTN];
    logic [DW-1:0]      db_cnt_d   [NUM_BTN];
    logic [HW-1:0]      hold_cnt_q [NUM_BTN];
    logic [HW-1:0]      hold_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] sample;

    // Prescaler: wrapping counter, tick registered on its last count.
    always_comb begin
        tick_cnt_d = tick_cnt_q + TW'(1);
        tick_d     = 1'b0;
        if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            tick_d     = 1'b1;
        end
    end

    // Synchroniser shift and polarity normalisation (sample: 1 = pressed).
    always_comb begin
        s1_d   = btn_raw;
        s2_d   = s1_q;
        sample = s2_q ^ IDLE_PINS;
    end

    // Per-channel debounce, edge events and long-press hold counting.
    always_comb begin
        level_d    = level_q;
        press_d    = '0;
        release_d  = '0;
        long_d     = '0;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            // A sample matching the accepted level cancels any pending change.
            if (sample[i] == level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (tick_q) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_cnt_d[i]  = '0;
                    level_d[i]   = sample[i];
                    press_d[i]   = sample[i];
                    release_d[i] = ~sample[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DW'(1);
                end
            end

            // Saturating hold counter; the pulse fires only on reaching the
            // limit, so one press yields at most one long event.
            if (!level_q[i]) begin
                hold_cnt_d[i] = '0;
            end else if (tick_q && (hold_cnt_q[i] != HOLD_MAX)) begin
                hold_cnt_d[i] = hold_cnt_q[i] + HW'(1);
                if (hold_cnt_q[i] == HOLD_LAST) begin
                    long_d[i] = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
            s1_q       <= IDLE_PINS;
            s2_q       <= IDLE_PINS;
            level_q    <= '0;
            press_q    <= '0;
            release_q  <= '0;
            long_q     <= '0;
            db_cnt_q   <= '{default: '0};
            hold_cnt_q <= '{default: '0};
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_long    = long_q;
    assign tick        = tick_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with a small configuration
// (TICK_DIV=10, DEBOUNCE_TICKS=4, LONG_TICKS=8, active-low pins).
module tb_button_conditioner;

  localparam int NUM_BTN = 4;
  localparam int TDIV    = 10;
  localparam int DEB     = 4;
  localparam int LONG    = 8;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_raw = 4'hF;
  logic [3:0] btn_level, btn_press, btn_release, btn_long;
  logic       tick;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BTN(NUM_BTN), .CLK_FREQ(10_000), .TICK_DIV(TDIV),
    .DEBOUNCE_TICKS(DEB), .LONG_TICKS(LONG), .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_long(btn_long), .tick(tick)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Pins reach the comparison two clocks after being driven; a change is
  // accepted once DEB ticks have been counted while it kept differing;
  // a press held for LONG ticks fires one long event.
  logic [3:0] m_pin_d1, m_pin_d2;
  logic [3:0] m_level, m_press, m_release, m_long;
  logic       m_tick;
  int         m_cyc;
  int         m_run [4];
  int         m_held[4];

  wire [16:0] dut_out = {btn_level, btn_press, btn_release, btn_long, tick};
  wire [16:0] mdl_out = {m_level, m_press, m_release, m_long, m_tick};

  task automatic model_edge(input logic r, input logic [3:0] raw);
    logic [3:0] pressed_now;
    logic [3:0] lvl;
    if (r) begin
      m_pin_d1 = 4'hF; m_pin_d2 = 4'hF;
      m_level = '0; m_press = '0; m_release = '0; m_long = '0;
      m_tick = 1'b0; m_cyc = 0;
      for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_held[i] = 0; end
    end else begin
      pressed_now = ~m_pin_d2;
      lvl = m_level;
      m_press = '0; m_release = '0; m_long = '0;
      for (int i = 0; i < 4; i++) begin
        if (pressed_now[i] != lvl[i]) begin
          if (m_tick) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == DEB) begin
              m_level[i]   = pressed_now[i];
              m_press[i]   = pressed_now[i];
              m_release[i] = ~pressed_now[i];
              m_run[i]     = 0;
            end
          end
        end else begin
          m_run[i] = 0;
        end
        if (!lvl[i]) m_held[i] = 0;
        else if (m_tick && m_held[i] < LONG) begin
          m_held[i] = m_held[i] + 1;
          if (m_held[i] == LONG) m_long[i] = 1'b1;
        end
      end
      m_cyc  = m_cyc + 1;
      m_tick = (m_cyc % TDIV) == 0;
      m_pin_d2 = m_pin_d1;
      m_pin_d1 = raw;
    end
  endtask

  // ---------------- driver ----------------
  // Drive inputs, take one clock edge, advance the model, sample 1 time unit later.
  task automatic step(input logic r, input logic [3:0] raw);
    rst = r;
    btn_raw = raw;
    @(posedge clk);
    model_edge(r, raw);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int first_tick = -1;
    int last_tick = -1;
    int bad_period = 0;
    repeat (3) step(1'b1, 4'hF);
    checks++;
    if (dut_out !== 17'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", dut_out);
    end
    for (int k = 1; k <= 200; k++) begin
      step(1'b0, 4'hF);
      checks++;
      if (dut_out !== mdl_out) begin
        errors++; $display("FAIL reset_idle cyc %0d: got %h expected %h", k, dut_out, mdl_out);
      end
      if (tick) begin
        if (first_tick < 0) first_tick = k;
        else if (k - last_tick != TDIV) bad_period++;
        last_tick = k;
      end
    end
    checks++;
    if (first_tick != TDIV) begin
      errors++; $display("FAIL first_tick: got cycle %0d expected %0d", first_tick, TDIV);
    end
    checks++;
    if (bad_period != 0) begin
      errors++; $display("FAIL tick_period: got %0d bad gaps expected 0", bad_period);
    end
  endtask

  task automatic test_clean_press();
    int nt = 0;
    int others = 0;
    bit seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      step(1'b0, 4'hE);
      checks++;
      if (dut_out !== mdl_out) begin
        errors++; $display("FAIL clean_press cyc %0d: got %h expected %h", k, dut_out, mdl_out);
      end
      if (btn_press[0]) seen = 1;
      else if (k >= 1 && tick) nt++;
      if (btn_level[3:1] != 0 || btn_press[3:1] != 0 || btn_release != 0 || btn_long != 0) others++;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL clean_press_timeout: got no press expected press[0]");
    end
    checks++;
    if (nt != DEB) begin
      errors++; $display("FAIL clean_press_ticks: got %0d ticks expected %0d", nt, DEB);
    end
    checks++;
    if (others != 0) begin
      errors++; $display("FAIL clean_press_isolation: got %0d stray cycles expected 0", others);
    end
    repeat (60) begin
      step(1'b0, 4'hF);
      checks++;
      if (dut_out !== mdl_out) begin
        errors++; $display("FAIL clean_release: got %h expected %h", dut_out, mdl_out);
      end
    end
  endtask

  task automatic test_bounce();
    int bounce_ev = 0;
    int nt = 0;
    int npress = 0;
    bit seen = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, (k < 25) ? 4'hD : 4'hF);
      checks++;
      if (dut_out !== mdl_out) begin
        errors++; $display("FAIL bounce cyc %0d: got %h expected %h", k, dut_out, mdl_out);
      end
      if (btn_press != 0 || btn_release != 0 || btn_level != 0) bounce_ev++;
    end
    checks++;
    if (bounce_ev != 0) begin
      errors++; $display("FAIL bounce_quiet: got %0d event cycles expected 0", bounce_ev);
    end
    for (int k = 0; k < 200 && !seen; k++) begin
      step(1'b0, 4'hD);
      checks++;
      if (dut_out !== mdl_out) begin
        errors++; $display("FAIL bounce_settle cyc %0d: got %h expected %h", k, dut_out, mdl_out);
      end
      if (btn_press[1]) begin seen = 1; npress++; end
      else if (k >= 1 && tick) nt++;
    end
    checks++;
    if (!seen || nt != DEB) begin
      errors++; $display("FAIL bounce_press: got seen=%0d ticks=%0d expected seen=1 ticks=%0d", seen, nt, DEB);
    end
    repeat (20) begin
      step(1'b0, 4'hD);
      if (btn_press[1]) npress++;
    end
    checks++;
    if (npress != 1) begin
      errors++; $display("FAIL bounce_single_press: got %0d expected 1", npress);
    end
    repeat (60) step(1'b0, 4'hF);
  endtask

  task automatic test_long_press();
    int p_at = -1;
    int l_at = -1;
    int npress = 0;
    int nlong = 0;
    int nrel = 0;
    for (int k = 0; k < 150; k++) begin
      step(1'b0, 4'hB);
      checks++;
      if (dut_out !== mdl_out) begin
        errors++; $display("FAIL long_hold cyc %0d: got %h expected %h", k, dut_out, mdl_out);
      end
      if (btn_press[2]) begin npress++; p_at = k; end
      if (btn_long[2])  begin nlong++;  l_at = k; end
    end
    checks++;
    if (npress != 1 || nlong != 1) begin
      errors++; $display("FAIL long_counts: got press=%0d long=%0d expected 1/1", npress, nlong);
    end
    checks++;
    if (l_at - p_at != LONG * TDIV) begin
      errors++; $display("FAIL long_delay: got %0d cycles expected %0d", l_at - p_at, LONG * TDIV);
    end
    for (int k = 0; k < 150; k++) begin
      step(1'b0, 4'hF);
      checks++;
      if (dut_out !== mdl_out) begin
        errors++; $display("FAIL long_release cyc %0d: got %h expected %h", k, dut_out, mdl_out);
      end
      if (btn_release[2]) nrel++;
      if (btn_long[2]) nlong++;
    end
    checks++;
    if (nrel != 1 || nlong != 1) begin
      errors++; $display("FAIL long_after_release: got release=%0d long=%0d expected 1/1", nrel, nlong);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] first_press = '0;
    for (int k = 0; k < 200 && first_press == 0; k++) begin
      step(1'b0, 4'h6);
      checks++;
      if (dut_out !== mdl_out) begin
        errors++; $display("FAIL simul cyc %0d: got %h expected %h", k, dut_out, mdl_out);
      end
      first_press = btn_press;
    end
    checks++;
    if (first_press !== 4'b1001) begin
      errors++; $display("FAIL simul_press: got %b expected 1001", first_press);
    end
    repeat (60) begin
      step(1'b0, 4'hF);
      checks++;
      if (dut_out !== mdl_out) begin
        errors++; $display("FAIL simul_release: got %h expected %h", dut_out, mdl_out);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    int nt = 0;
    bit reached = 0;
    bit seen = 0;
    for (int k = 0; k < 200 && !reached; k++) begin
      step(1'b0, 4'hE);
      reached = (m_run[0] == 2);
    end
    checks++;
    if (!reached) begin
      errors++; $display("FAIL midreset_setup: got no partial debounce expected run=2");
    end
    step(1'b1, 4'hE);
    checks++;
    if (dut_out !== 17'h0) begin
      errors++; $display("FAIL midreset_outputs: got %h expected 0", dut_out);
    end
    for (int k = 0; k < 200 && !seen; k++) begin
      step(1'b0, 4'hE);
      checks++;
      if (dut_out !== mdl_out) begin
        errors++; $display("FAIL midreset cyc %0d: got %h expected %h", k, dut_out, mdl_out);
      end
      if (btn_press[0]) seen = 1;
      else if (tick) nt++;
    end
    checks++;
    if (!seen || nt != DEB) begin
      errors++; $display("FAIL midreset_press: got seen=%0d ticks=%0d expected seen=1 ticks=%0d", seen, nt, DEB);
    end
    repeat (60) step(1'b0, 4'hF);
  endtask

  task automatic test_random();
    logic [3:0] target = 4'hF;
    logic [3:0] raw;
    int age[4];
    for (int i = 0; i < 4; i++) age[i] = 100;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 149) == 0) begin target[i] = ~target[i]; age[i] = 0; end
        else age[i]++;
        raw[i] = (age[i] < 15 && $urandom_range(0, 2) == 0) ? ~target[i] : target[i];
      end
      step(($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0, raw);
      checks++;
      if (dut_out !== mdl_out) begin
        errors++; $display("FAIL random cyc %0d: got %h expected %h", k, dut_out, mdl_out);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_simultaneous();
    test_reset_mid_debounce();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
